// File: rtl/if_id_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package if_id_pkg;

    localparam int PC_W_DEF    = 32;
    localparam int INSTR_W_DEF = 32;

    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [PC_W_DEF-1:0]    pc_plus4;
        logic [INSTR_W_DEF-1:0] instr;
        logic                   dslot;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch/decode side signals of the instruction queue; master is the pipeline, slave the queue.
interface if_id_queue_if #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
);
    import if_id_pkg::*;

    logic                       flushD;
    logic                       pushF;
    logic                       readyF;
    logic [PC_W-1:0]            pcF;
    logic [PC_W-1:0]            pc_plus4F;
    logic [INSTR_W-1:0]         instrF;
    logic                       is_in_delayslot_iF;
    logic                       stallD;
    logic                       validD;
    logic [PC_W-1:0]            pcD;
    logic [PC_W-1:0]            pc_plus4D;
    logic [INSTR_W-1:0]         instrD;
    logic                       is_in_delayslot_iD;
    logic [$clog2(DEPTH):0]     countD;

    modport master (
        output flushD, pushF, pcF, pc_plus4F, instrF, is_in_delayslot_iF, stallD,
        input  readyF, validD, pcD, pc_plus4D, instrD, is_in_delayslot_iD, countD
    );

    modport slave (
        input  flushD, pushF, pcF, pc_plus4F, instrF, is_in_delayslot_iF, stallD,
        output readyF, validD, pcD, pc_plus4D, instrD, is_in_delayslot_iD, countD
    );

endinterface

// File: rtl/if_id_queue_fifo_ctrl.sv
// Pointer/occupancy control for the IF/ID queue: accepts pushes, retires pops, flushes.
module fifo_ctrl import if_id_pkg::*; #(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_req_i,
    input  logic          stall_i,
    output logic          push_o,
    output logic          ready_o,
    output logic          valid_o,
    output logic [PW-1:0] wr_ptr_o,
    output logic [PW-1:0] rd_ptr_o,
    output logic [CW-1:0] count_o
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop;

    // ready/valid come from registered count only, so no F->D combinational path exists
    assign ready_o = (count_q != CW'(DEPTH));
    assign valid_o = (count_q != '0);
    assign push_o  = push_req_i & ready_o;
    assign pop     = valid_o & ~stall_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_o) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_o && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push_o) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue replacing the IF/ID register; empty head reads as a NOP bubble.
module if_id_queue import if_id_pkg::*; #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    if_id_queue_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]    pc_q       [DEPTH];
    logic [PC_W-1:0]    pc_plus4_q [DEPTH];
    logic [INSTR_W-1:0] instr_q    [DEPTH];
    logic               dslot_q    [DEPTH];

    logic          push;
    logic          valid;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (bus.flushD),
        .push_req_i (bus.pushF),
        .stall_i    (bus.stallD),
        .push_o     (push),
        .ready_o    (bus.readyF),
        .valid_o    (valid),
        .wr_ptr_o   (wr_ptr),
        .rd_ptr_o   (rd_ptr),
        .count_o    (count)
    );

    // Storage is never reset: a write during flush/reset is harmless because count returns to 0
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]       <= bus.pcF;
            pc_plus4_q[wr_ptr] <= bus.pc_plus4F;
            instr_q[wr_ptr]    <= bus.instrF;
            dslot_q[wr_ptr]    <= bus.is_in_delayslot_iF;
        end
    end

    assign bus.validD             = valid;
    assign bus.countD             = count;
    assign bus.pcD                = valid ? pc_q[rd_ptr]       : '0;
    assign bus.pc_plus4D          = valid ? pc_plus4_q[rd_ptr] : '0;
    assign bus.instrD             = valid ? instr_q[rd_ptr]    : INSTR_W'(NOP_INSTR);
    assign bus.is_in_delayslot_iD = valid & dslot_q[rd_ptr];

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue with DEPTH=4.
module tb_if_id_queue;
    import if_id_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    if_id_queue_if #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32)) bus ();

    if_id_queue #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input if_id_entry_t e);
        bus.pushF              = 1'b1;
        bus.pcF                = e.pc;
        bus.pc_plus4F          = e.pc_plus4;
        bus.instrF             = e.instr;
        bus.is_in_delayslot_iF = e.dslot;
    endtask

    function automatic if_id_entry_t mk(input logic [31:0] pc, input logic [31:0] instr, input logic dslot);
        if_id_entry_t e;
        e.pc       = pc;
        e.pc_plus4 = pc + 32'd4;
        e.instr    = instr;
        e.dslot    = dslot;
        return e;
    endfunction

    initial begin
        rst = 1'b1;
        bus.flushD = 1'b0; bus.pushF = 1'b0; bus.stallD = 1'b0;
        bus.pcF = '0; bus.pc_plus4F = '0; bus.instrF = '0; bus.is_in_delayslot_iF = 1'b0;
        step();
        step();
        rst = 1'b0;

        // reset state
        chk("rst_validD", bus.validD, 0);
        chk("rst_readyF", bus.readyF, 1);
        chk("rst_countD", bus.countD, 0);
        chk("rst_pcD",    bus.pcD, 0);
        chk("rst_pc4D",   bus.pc_plus4D, 0);
        chk("rst_instrD", bus.instrD, 0);
        chk("rst_dslotD", bus.is_in_delayslot_iD, 0);

        // single push, then pop back to a bubble
        set_push(mk(32'hBFC00000, 32'h24080001, 1'b0));
        step();
        bus.pushF = 1'b0;
        chk("single_validD", bus.validD, 1);
        chk("single_pcD",    bus.pcD, 32'hBFC00000);
        chk("single_pc4D",   bus.pc_plus4D, 32'hBFC00004);
        chk("single_instrD", bus.instrD, 32'h24080001);
        chk("single_countD", bus.countD, 1);
        step();
        chk("bubble_validD", bus.validD, 0);
        chk("bubble_pcD",    bus.pcD, 0);
        chk("bubble_pc4D",   bus.pc_plus4D, 0);
        chk("bubble_instrD", bus.instrD, 0);
        chk("bubble_countD", bus.countD, 0);

        // fill under stall, fifth push refused, drain in order
        bus.stallD = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            set_push(mk(32'h100 + 32'(16 * i), 32'hA0 + 32'(i), i[0]));
            step();
        end
        chk("full_countD", bus.countD, 4);
        chk("full_readyF", bus.readyF, 0);
        set_push(mk(32'h999, 32'hDEAD, 1'b1));
        step();
        bus.pushF = 1'b0;
        chk("over_countD", bus.countD, 4);
        chk("over_readyF", bus.readyF, 0);
        bus.stallD = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_validD", bus.validD, 1);
            chk("drain_pcD",    bus.pcD, 32'h100 + 32'(16 * i));
            chk("drain_pc4D",   bus.pc_plus4D, 32'h104 + 32'(16 * i));
            chk("drain_instrD", bus.instrD, 32'hA0 + 32'(i));
            chk("drain_dslotD", bus.is_in_delayslot_iD, 64'(i[0]));
            step();
        end
        chk("drained_validD", bus.validD, 0);
        chk("drained_countD", bus.countD, 0);

        // full queue with push and pop in the same cycle: push refused
        bus.stallD = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            set_push(mk(32'h200 + 32'(4 * i), 32'hB0 + 32'(i), 1'b0));
            step();
        end
        set_push(mk(32'h777, 32'h777, 1'b0));
        bus.stallD = 1'b0;
        step();
        bus.pushF  = 1'b0;
        bus.stallD = 1'b1;
        chk("fullpp_countD", bus.countD, 3);
        chk("fullpp_readyF", bus.readyF, 1);
        chk("fullpp_pcD",    bus.pcD, 32'h204);

        // flush with 3 entries and a simultaneous push
        bus.flushD = 1'b1;
        set_push(mk(32'h888, 32'h888, 1'b1));
        step();
        bus.flushD = 1'b0;
        bus.pushF  = 1'b0;
        chk("flush_countD", bus.countD, 0);
        chk("flush_validD", bus.validD, 0);
        chk("flush_instrD", bus.instrD, 0);
        set_push(mk(32'h300, 32'h55, 1'b1));
        step();
        bus.pushF = 1'b0;
        chk("postflush_validD", bus.validD, 1);
        chk("postflush_pcD",    bus.pcD, 32'h300);
        chk("postflush_dslotD", bus.is_in_delayslot_iD, 1);
        chk("postflush_countD", bus.countD, 1);

        // reset mid-stream with 2 entries and stall held
        set_push(mk(32'h304, 32'h56, 1'b1));
        step();
        bus.pushF = 1'b0;
        chk("prerst_countD", bus.countD, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_countD", bus.countD, 0);
        chk("midrst_validD", bus.validD, 0);
        chk("midrst_readyF", bus.readyF, 1);
        chk("midrst_dslotD", bus.is_in_delayslot_iD, 0);

        // steady push+pop with two entries resident, wrapping pointers several times
        set_push(mk(32'h1000, 32'h1, 1'b0));
        step();
        set_push(mk(32'h1004, 32'h1, 1'b0));
        step();
        bus.stallD = 1'b0;
        for (int i = 2; i < 12; i++) begin
            set_push(mk(32'h1000 + 32'(4 * i), 32'h1, 1'b0));
            chk("stream_pcD",    bus.pcD, 32'h1000 + 32'(4 * (i - 2)));
            chk("stream_countD", bus.countD, 2);
            step();
        end
        bus.pushF = 1'b0;
        chk("tail0_pcD", bus.pcD, 32'h1028);
        step();
        chk("tail1_pcD", bus.pcD, 32'h102C);
        step();
        chk("tail_validD", bus.validD, 0);
        chk("tail_countD", bus.countD, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised fetch-to-decode instruction queue that replaces the single-entry IF/ID pipeline register. It holds up to DEPTH fetched instructions, each with its PC, PC+4 and delay-slot flag. Fetch and decode are decoupled by a valid/ready handshake, so a decode stall no longer has to freeze fetch immediately. It sits between the fetch stage (F) and the decode stage (D), and keeps the register's flush and stall semantics on the D side.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- PC_W, 32: width of the PC and PC+4 fields.
- INSTR_W, 32: width of the instruction word.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flushD  in  1  discard every queued entry and any push in the same cycle.
- pushF  in  1  fetch presents a valid instruction this cycle.
- readyF  out  1  queue can accept a push this cycle.
- pcF  in  PC_W  PC of the pushed instruction.
- pc_plus4F  in  PC_W  PC+4 of the pushed instruction.
- instrF  in  INSTR_W  pushed instruction word.
- is_in_delayslot_iF  in  1  pushed instruction is in a branch delay slot.
- stallD  in  1  decode does not consume the head entry this cycle.
- validD  out  1  head entry is valid.
- pcD  out  PC_W  PC of the head entry.
- pc_plus4D  out  PC_W  PC+4 of the head entry.
- instrD  out  INSTR_W  instruction word of the head entry.
- is_in_delayslot_iD  out  1  delay-slot flag of the head entry.
- countD  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- State:
  - storage array of DEPTH entries, each {pc, pc_plus4, instr, dslot};
  - write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits;
  - count, $clog2(DEPTH)+1 bits.
- Handshake signals:
  - readyF = (count != DEPTH); depends on the registered count only.
  - push = pushF & readyF.
  - pop = validD & ~stallD.
- Push: writes the entry at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap).
- Pop: rd_ptr increments modulo DEPTH.
- Count update: +1 on push only, -1 on pop only, unchanged when push and pop happen together.
- Full queue: readyF=0, so a push is refused even if a pop happens in the same cycle. Fetch must hold its data and retry.
- Empty queue: validD=0.
  - pcD, pc_plus4D, instrD and is_in_delayslot_iD are forced to 0, giving a NOP bubble identical to a flushed IF/ID register.
  - A pop cannot occur.
- Flush (flushD=1): next cycle count=0, wr_ptr=0, rd_ptr=0.
  - Any push and any pop in the flush cycle are ignored.
  - Storage contents are don't-care because outputs are masked.
- Priority: rst > flushD > push/pop.
- Reset: same effect as flush. Storage need not be reset.
- Asserting stallD while empty has no effect.
- Asserting pushF while readyF=0 has no effect.
- No bypass: a pushed entry is never visible on the D outputs in the same cycle.

## Timing
- Latency: a push at edge N makes the entry visible on the D outputs after edge N if the queue was empty, with validD=1 in cycle N+1.
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- D outputs are combinational reads of registered state (storage[rd_ptr] masked by count!=0). There is no combinational path from pushF or the F data inputs to any output.
- readyF and countD are functions of registered state only.
- Outputs after reset: validD=0, readyF=1, countD=0, all D data outputs 0.

## Structure
- Shared package if_id_pkg:
  - typedef if_id_entry_t {pc, pc_plus4, instr, dslot}, sized from PC_W and INSTR_W defaults;
  - constant NOP_INSTR = 0.
- One natural sub-module, fifo_ctrl: pointers, count, readyF and validD generation.
- The entry storage array and output masking stay in if_id_queue.

## Test plan
- Reset then single push of pc=0xBFC00000, instr=0x24080001 -> next cycle validD=1, pcD=0xBFC00000, pc_plus4D=0xBFC00004, countD=1; with stallD=0 the following cycle gives validD=0 and all D outputs 0.
- Fill with DEPTH=4 pushes while stallD=1 -> countD=4, readyF=0; a fifth push is ignored; release stallD -> the four entries pop in push order.
- Steady push and pop each cycle across more than 2*DEPTH entries -> countD constant, pointer wrap-around yields the PC sequence in order with no loss or duplication.
- Full queue, pushF=1 and pop in the same cycle -> push refused, countD 4->3, readyF=1 the next cycle.
- flushD=1 with 3 entries and a simultaneous push -> next cycle countD=0, validD=0, instrD=0; a following push reappears with 1-cycle latency.
- rst asserted mid-stream with 2 entries and stallD=1 -> next cycle countD=0, validD=0, readyF=1, is_in_delayslot_iD=0.
